// File: rtl/madd_eval_pkg.sv
// madd_eval_pkg
// Shared definitions for the madd error-evaluation response path:
//   - eval_state_t    : run-control FSM states
//   - MADD_OW/MADD_CW : default output-word and counter widths
//   - EVAL_PIPE_DEPTH : cycles spent draining the datapath after the last accept
package madd_eval_pkg;

  localparam int MADD_OW         = 4;
  localparam int MADD_CW         = 16;
  localparam int EVAL_PIPE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } eval_state_t;

endpackage

// File: rtl/err_absdiff.sv
// err_absdiff
// Stage-1 register of the error pipeline: registers |exact - approx| and a
// nonzero flag for every valid input pair.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   valid_i        : input pair is valid this cycle
//   exact_i        : golden word (unsigned)
//   approx_i       : approximate word (unsigned)
//   valid_o        : registered valid
//   ad_o           : registered absolute difference
//   neq_o          : registered (ad != 0)
module err_absdiff #(
  parameter int OW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [OW-1:0] exact_i,
  input  logic [OW-1:0] approx_i,
  output logic          valid_o,
  output logic [OW-1:0] ad_o,
  output logic          neq_o
);

  logic [OW-1:0] ad_d;

  // Subtract the smaller from the larger so the result never wraps.
  always_comb begin
    ad_d = '0;
    if (exact_i >= approx_i) ad_d = exact_i - approx_i;
    else                     ad_d = approx_i - exact_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      ad_o    <= '0;
      neq_o   <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        ad_o  <= ad_d;
        neq_o <= (exact_i != approx_i);
      end
    end
  end

endmodule

// File: rtl/madd_err_accum.sv
// madd_err_accum
// Streaming error-statistics accumulator. Accepts N (exact, approx) pairs,
// then reports error count, sum of absolute errors and maximum absolute error.
// Datapath: capture register -> err_absdiff (stage 1) -> accumulators (stage 2),
// so a pair accepted at edge k is reflected in the results after edge k+2.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a run (honoured in IDLE/DONE only)
//   num_samples   : run length N, latched when start is honoured
//   in_valid      : pair presented; in_ready: pair accepted this cycle
//   in_exact      : golden word; in_approx: approximate word
//   busy          : RUN or DRAIN; done: results valid and stable
//   sample_count, err_count, sum_abs_err, max_abs_err : run results
module madd_err_accum
  import madd_eval_pkg::*;
#(
  parameter int OW = MADD_OW,
  parameter int CW = MADD_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OW-1:0]    in_exact,
  input  logic [OW-1:0]    in_approx,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    sample_count,
  output logic [CW-1:0]    err_count,
  output logic [CW+OW-1:0] sum_abs_err,
  output logic [OW-1:0]    max_abs_err
);

  localparam int DRAIN_W = (EVAL_PIPE_DEPTH > 2) ? $clog2(EVAL_PIPE_DEPTH) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(EVAL_PIPE_DEPTH - 1);

  eval_state_t        state_q;
  logic [CW-1:0]      n_q;
  logic [CW-1:0]      acc_cnt_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               done_q;

  logic               accept;
  logic               start_ok;

  assign accept   = in_valid && in_ready_q;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  // ---------------------------------------------------------------------------
  // Run-control FSM, accept counter and registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      acc_cnt_q  <= '0;
      drain_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            n_q       <= num_samples;
            acc_cnt_q <= '0;
            drain_q   <= '0;
            if (num_samples != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end else begin
              // Empty run: results are already the cleared zeros.
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt_q <= acc_cnt_q + CW'(1);
            // Nth accept: drop ready now so no N+1th pair can slip in.
            if (acc_cnt_q == n_q - CW'(1)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              drain_q    <= '0;
            end
          end
        end
        DRAIN: begin
          // DONE lands on the same edge as the last stage-2 update.
          if (drain_q == DRAIN_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // ---------------------------------------------------------------------------
  // Capture register: holds the accepted pair for stage 1
  // ---------------------------------------------------------------------------
  logic          cap_vld_q;
  logic [OW-1:0] cap_exact_q;
  logic [OW-1:0] cap_approx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_q    <= 1'b0;
      cap_exact_q  <= '0;
      cap_approx_q <= '0;
    end else begin
      cap_vld_q <= accept;
      if (accept) begin
        cap_exact_q  <= in_exact;
        cap_approx_q <= in_approx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: absolute difference
  // ---------------------------------------------------------------------------
  logic          s1_vld;
  logic [OW-1:0] s1_ad;
  logic          s1_neq;

  err_absdiff #(.OW(OW)) u_absdiff (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (cap_vld_q),
    .exact_i  (cap_exact_q),
    .approx_i (cap_approx_q),
    .valid_o  (s1_vld),
    .ad_o     (s1_ad),
    .neq_o    (s1_neq)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: accumulators
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    sample_count_q, sample_count_d;
  logic [CW-1:0]    err_count_q,    err_count_d;
  logic [CW+OW-1:0] sum_abs_err_q,  sum_abs_err_d;
  logic [OW-1:0]    max_abs_err_q,  max_abs_err_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    sum_abs_err_d  = sum_abs_err_q;
    max_abs_err_d  = max_abs_err_q;
    // A start is only honoured with the pipeline empty, so clearing never
    // collides with a stage-1 valid.
    if (start_ok) begin
      sample_count_d = '0;
      err_count_d    = '0;
      sum_abs_err_d  = '0;
      max_abs_err_d  = '0;
    end else if (s1_vld) begin
      sample_count_d = sample_count_q + CW'(1);
      err_count_d    = err_count_q + CW'(s1_neq);
      // N <= 2^CW-1 and ad <= 2^OW-1, so CW+OW bits never wrap.
      sum_abs_err_d  = sum_abs_err_q + (CW+OW)'(s1_ad);
      if (s1_ad > max_abs_err_q) max_abs_err_d = s1_ad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_abs_err_q  <= '0;
      max_abs_err_q  <= '0;
    end else begin
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      sum_abs_err_q  <= sum_abs_err_d;
      max_abs_err_q  <= max_abs_err_d;
    end
  end

  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign sum_abs_err  = sum_abs_err_q;
  assign max_abs_err  = max_abs_err_q;

endmodule

// File: tb/tb_madd_err_accum.sv
// tb_madd_err_accum
// Self-checking bench: table of directed runs, hand-written reset/idle
// sequences, randomized runs against an arithmetic reference model, and a
// narrow-counter instance exercising the no-wrap width rule.
module tb_madd_err_accum;

  localparam int OW = 4;
  localparam int CW = 16;
  localparam int WCW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance
  logic             start, in_valid, in_ready, busy, done;
  logic [CW-1:0]    num_samples, sample_count, err_count;
  logic [OW-1:0]    in_exact, in_approx, max_abs_err;
  logic [CW+OW-1:0] sum_abs_err;

  madd_err_accum #(.OW(OW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_exact(in_exact),
    .in_approx(in_approx), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err)
  );

  // Narrow-counter instance
  logic              w_start, w_in_valid, w_in_ready, w_busy, w_done;
  logic [WCW-1:0]    w_num_samples, w_sample_count, w_err_count;
  logic [OW-1:0]     w_in_exact, w_in_approx, w_max_abs_err;
  logic [WCW+OW-1:0] w_sum_abs_err;

  madd_err_accum #(.OW(OW), .CW(WCW)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .num_samples(w_num_samples),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_exact(w_in_exact),
    .in_approx(w_in_approx), .busy(w_busy), .done(w_done),
    .sample_count(w_sample_count), .err_count(w_err_count),
    .sum_abs_err(w_sum_abs_err), .max_abs_err(w_max_abs_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus for the current run and the edges at which pairs were accepted.
  logic [OW-1:0] pe[$];
  logic [OW-1:0] pa[$];
  int            acc_edges[$];

  // Reference model: statistics straight from the pair list.
  function automatic void ref_model(output int c, output int e, output int s, output int m);
    c = pe.size(); e = 0; s = 0; m = 0;
    for (int i = 0; i < pe.size(); i++) begin
      int d;
      d = int'(pe[i]) - int'(pa[i]);
      if (d < 0) d = -d;
      if (d != 0) e++;
      s += d;
      if (d > m) m = d;
    end
  endfunction

  // Pairs accepted two or more edges ago must be in the sample count.
  task automatic check_visible(input string tag);
    int vis;
    vis = 0;
    foreach (acc_edges[i]) if (acc_edges[i] <= cyc - 2) vis++;
    check({tag, "_visible_count"}, sample_count, vis);
  endtask

  task automatic check_results(input string tag, input int c, input int e, input int s, input int m);
    check({tag, "_sample_count"}, sample_count, c);
    check({tag, "_err_count"}, err_count, e);
    check({tag, "_sum_abs_err"}, sum_abs_err, s);
    check({tag, "_max_abs_err"}, max_abs_err, m);
  endtask

  // One complete run of pe/pa; expects to be called just after a clock edge.
  task automatic run_seq(input int n, input int gap_lo, input int gap_hi, input bit mid_start,
                         input int ec, input int ee, input int es, input int em, input string tag);
    logic [63:0] hold_sum;
    start = 1'b1; num_samples = CW'(n);
    step();
    start = 1'b0;
    acc_edges.delete();
    if (n == 0) begin
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ready"}, in_ready, 0);
      check_results(tag, 0, 0, 0, 0);
      return;
    end
    check({tag, "_ready_first"}, in_ready, 1);
    check({tag, "_busy_run"}, busy, 1);
    check({tag, "_cleared"}, sample_count, 0);
    for (int i = 0; i < n; i++) begin
      int g;
      g = int'($urandom_range(gap_hi, gap_lo));
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        step();
        check_visible(tag);
      end
      check({tag, "_ready_before_accept"}, in_ready, 1);
      in_valid = 1'b1; in_exact = pe[i]; in_approx = pa[i];
      if (mid_start && i == 1) begin
        start = 1'b1; num_samples = CW'(1);
      end
      step();
      start = 1'b0;
      acc_edges.push_back(cyc);
      if (i < n - 1) check_visible(tag);
    end
    in_valid = 1'b0;
    check({tag, "_ready_after_last"}, in_ready, 0);
    check({tag, "_busy_drain1"}, busy, 1);
    check({tag, "_done_drain1"}, done, 0);
    check_visible(tag);
    step();
    check({tag, "_done_drain2"}, done, 0);
    check({tag, "_busy_drain2"}, busy, 1);
    check_visible(tag);
    step();
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_ready_done"}, in_ready, 0);
    check_results(tag, ec, ee, es, em);
    // Results hold in DONE even with in_valid toggling.
    hold_sum = 64'(sum_abs_err);
    for (int j = 0; j < 3; j++) begin
      in_valid = j[0]; in_exact = 4'd15; in_approx = 4'd0;
      step();
    end
    in_valid = 1'b0;
    check({tag, "_hold_sum"}, sum_abs_err, hold_sum);
    check({tag, "_hold_count"}, sample_count, ec);
    check({tag, "_hold_done"}, done, 1);
  endtask

  typedef struct {
    int            n;
    int            gap_lo;
    int            gap_hi;
    bit            mid_start;
    logic [OW-1:0] ex[4];
    logic [OW-1:0] ap[4];
    int            exp_cnt;
    int            exp_err;
    int            exp_sum;
    int            exp_max;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{n: 4, gap_lo: 0, gap_hi: 0, mid_start: 1'b0,
               ex: '{4'd5, 4'd12, 4'd3, 4'd0}, ap: '{4'd5, 4'd10, 4'd7, 4'd15},
               exp_cnt: 4, exp_err: 3, exp_sum: 21, exp_max: 15};
    tbl[1] = '{n: 3, gap_lo: 1, gap_hi: 3, mid_start: 1'b0,
               ex: '{4'd1, 4'd2, 4'd9, 4'd0}, ap: '{4'd2, 4'd2, 4'd8, 4'd0},
               exp_cnt: 3, exp_err: 2, exp_sum: 2, exp_max: 1};
    tbl[2] = '{n: 0, gap_lo: 0, gap_hi: 0, mid_start: 1'b0,
               ex: '{4'd0, 4'd0, 4'd0, 4'd0}, ap: '{4'd0, 4'd0, 4'd0, 4'd0},
               exp_cnt: 0, exp_err: 0, exp_sum: 0, exp_max: 0};
    tbl[3] = '{n: 4, gap_lo: 0, gap_hi: 1, mid_start: 1'b1,
               ex: '{4'd1, 4'd0, 4'd8, 4'd6}, ap: '{4'd0, 4'd3, 4'd8, 4'd14},
               exp_cnt: 4, exp_err: 3, exp_sum: 12, exp_max: 8};

    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    in_exact = '0; in_approx = '0;
    w_start = 1'b0; w_num_samples = '0; w_in_valid = 1'b0;
    w_in_exact = '0; w_in_approx = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state and idle: in_valid without start is never accepted.
    check("reset_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check_results("reset", 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_exact = 4'd9; in_approx = 4'd1;
      step();
      check("idle_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    repeat (2) step();
    check_results("idle", 0, 0, 0, 0);

    // Directed table.
    for (int t = 0; t < 4; t++) begin
      pe.delete(); pa.delete();
      for (int i = 0; i < tbl[t].n; i++) begin
        pe.push_back(tbl[t].ex[i]);
        pa.push_back(tbl[t].ap[i]);
      end
      run_seq(tbl[t].n, tbl[t].gap_lo, tbl[t].gap_hi, tbl[t].mid_start,
              tbl[t].exp_cnt, tbl[t].exp_err, tbl[t].exp_sum, tbl[t].exp_max,
              $sformatf("tbl%0d", t));
    end

    // Reset one cycle after the 2nd of 4 accepts discards everything.
    start = 1'b1; num_samples = CW'(4);
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_exact = OW'(i + 3); in_approx = '0;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_results("abort", 0, 0, 0, 0);
    repeat (2) step();
    check_results("abort_flushed", 0, 0, 0, 0);
    pe.delete(); pa.delete();
    pe.push_back(4'd7); pa.push_back(4'd4);
    run_seq(1, 0, 0, 1'b0, 1, 1, 3, 3, "post_abort");

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      int n, c, e, s, m;
      n = int'($urandom_range(12, 1));
      pe.delete(); pa.delete();
      for (int i = 0; i < n; i++) begin
        pe.push_back(OW'($urandom_range(15, 0)));
        if ($urandom_range(3, 0) == 0) pa.push_back(pe[i]);
        else pa.push_back(OW'($urandom_range(15, 0)));
      end
      ref_model(c, e, s, m);
      run_seq(n, 0, 2, 1'b0, c, e, s, m, $sformatf("rand%0d", r));
    end

    // Narrow counters at full scale: 15 x |15-0| = 225 fits in 8 bits.
    begin
      bit seen;
      seen = 1'b0;
      w_start = 1'b1; w_num_samples = 4'd15;
      step();
      w_start = 1'b0;
      w_in_valid = 1'b1; w_in_exact = 4'd15; w_in_approx = 4'd0;
      for (int j = 0; j < 40 && !seen; j++) begin
        step();
        if (w_done) seen = 1'b1;
      end
      check("wide_done_seen", seen, 1);
      repeat (2) step();
      w_in_valid = 1'b0;
      check("wide_sample_count", w_sample_count, 15);
      check("wide_err_count", w_err_count, 15);
      check("wide_sum_abs_err", w_sum_abs_err, 225);
      check("wide_max_abs_err", w_max_abs_err, 15);
      check("wide_busy", w_busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/madd_err_accum.md
# madd_err_accum

Streaming error-statistics accumulator for approximate-arithmetic evaluation. It is the response side of the stimulus flow that drives 6-input/4-output `madd` circuits: it consumes (exact, approximate) output pairs and accumulates error metrics over a programmed sample count. It reports the error count, the sum of absolute errors and the maximum absolute error for the run. It sits between the DUT output capture and the host-readable result registers of the evaluation harness.

## Interface
- `OW`, 4, width of the exact and approximate output words.
- `CW`, 16, width of the sample-count and error-count registers.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `num_samples`  in  CW  number of samples N in the run; sampled when `start` is honoured.
- `in_valid`  in  1  an input pair is presented.
- `in_ready`  out  1  block accepts a pair this cycle.
- `in_exact`  in  OW  golden output, unsigned.
- `in_approx`  in  OW  approximate DUT output, unsigned.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE; results are valid and stable.
- `sample_count`  out  CW  pairs accumulated so far.
- `err_count`  out  CW  pairs with exact != approx.
- `sum_abs_err`  out  CW+OW  sum of |exact − approx|.
- `max_abs_err`  out  OW  maximum |exact − approx|.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start`:
  - Clear all four result registers and the accept counter.
  - Latch N.
  - Go to RUN if N>0; go to DONE if N=0, with results all zero.
- RUN:
  - `in_ready`=1 while the accept count is below N.
  - A pair is accepted on any edge where `in_valid && in_ready`.
  - Accepting the Nth pair moves to DRAIN.
- DRAIN: lasts exactly 2 cycles while the pipeline empties, then goes to DONE.
- DONE:
  - Results hold until `start` or `rst`.
  - `start` in DONE begins a new run; it is not a back-to-back overlap.
- `start` in RUN or DRAIN is ignored; `num_samples` is not resampled.
- Stage 1 registers `ad = |exact − approx|` as OW-bit unsigned, plus `neq = (ad != 0)` and a valid bit.
- Stage 2, on a stage-1 valid, updates the results:
  - `sample_count += 1`
  - `err_count += neq`
  - `sum_abs_err += ad`
  - `max_abs_err = max(max_abs_err, ad)`
- Width rule: N ≤ 2^CW−1 and ad ≤ 2^OW−1, so `sum_abs_err` cannot overflow; no saturation logic is required.
- `in_valid` low in RUN inserts bubbles. Results reflect exactly the accepted pairs.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready`=0, `busy`=0, `done`=0
  - all result outputs 0
  - pipeline valid bits 0
- `rst` mid-run aborts immediately: next cycle is IDLE with everything zero, and in-flight samples are discarded.
- Latency: a pair accepted at edge k is visible in the result outputs after edge k+2.
- `in_ready` is registered: it is 0 in the cycle after the Nth accept and in all non-RUN states.
- `done` rises on the same edge that the Nth sample's stage-2 update lands: the Nth accept at edge k puts DONE at edge k+2.
- `busy` and `done` are never high together.
- `start` honoured at edge s:
  - N>0: `in_ready`=1 from cycle s+1.
  - N=0: `done`=1 from cycle s+1.

## Structure
- Package `madd_eval_pkg`:
  - state enum `eval_state_t` {IDLE, RUN, DRAIN, DONE}
  - default width constants `MADD_OW=4`, `MADD_CW=16`
  - DRAIN length constant `EVAL_PIPE_DEPTH=2`
- Sub-module `err_absdiff`: stage-1 absolute-difference register with `ad`, `neq` and valid outputs, parameterized by OW.
- The top level holds the FSM, the accept counter and the stage-2 accumulators.

## Test plan
- Reset then idle: all outputs 0, `in_ready`=0; `in_valid` pulses without `start` are not accepted.
- N=4, pairs (5,5),(12,10),(3,7),(0,15), `in_valid` held high → `in_ready` for 4 cycles; `done` 2 cycles after the last accept; `sample_count`=4, `err_count`=3, `sum_abs_err`=21, `max_abs_err`=15.
- N=3 with `in_valid` gaps of 1–3 cycles, pairs (1,2),(2,2),(9,8) → counts 3/2, sum 2, max 1; stall cycles do not change results.
- N=0 `start` → `done` next cycle with all-zero results; `start` pulsed during RUN is ignored, N unchanged.
- `rst` asserted one cycle after the 2nd of 4 accepts → IDLE next cycle, all outputs zero; a fresh N=1 run with pair (7,4) then yields sum 3, max 3, `err_count` 1.
- Max-width run with CW=4, N=15, all pairs (15,0) → `sum_abs_err`=225 (8 bits, no wrap), `max_abs_err`=15, `err_count`=15.
